pcpi_dispatch: RTL

PCPI_DISPATCH -- requirements
Module: pcpi_dispatch

---
 rtl/pcpi_pkg.sv | 19 +
 rtl/pcpi_match.sv | 22 ++
 rtl/pcpi_dispatch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI custom-0 dispatcher: FSM states and
// instruction field positions.
package pcpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_DRAIN
  } state_t;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/pcpi_match.sv
// Combinational claim decode: the opcode must match and funct7 must name an
// existing channel, with every funct7 bit above the channel index clear.
module pcpi_match
  import pcpi_pkg::*;
#(
  parameter int         N_CH   = 4,
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
  parameter int         CH_W   = 2
) (
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  output logic            claim,
  output logic [CH_W-1:0] ch
);

  logic [6-CH_W:0] upper;

  assign ch    = funct7[CH_W-1:0];
  assign upper = funct7[6:CH_W];
  assign claim = (opcode == OPCODE) && (upper == '0) && (int'(ch) < N_CH);

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI front end that routes custom-0 instructions to one of N_CH accelerator
// channels, with a per-request timeout and sticky per-channel error flags.
module pcpi_dispatch
  import pcpi_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter logic [6:0]  OPCODE    = OPCODE_CUSTOM0,
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] ERR_VALUE = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcpi_valid,
  input  logic [31:0]          pcpi_insn,
  input  logic [31:0]          pcpi_rs1,
  input  logic [31:0]          pcpi_rs2,
  output logic                 pcpi_wr,
  output logic [31:0]          pcpi_rd,
  output logic                 pcpi_wait,
  output logic                 pcpi_ready,
  output logic [N_CH-1:0]      ch_valid,
  output logic [31:0]          ch_insn,
  output logic [31:0]          ch_rs1,
  output logic [31:0]          ch_rs2,
  output logic [N_CH-1:0]      ch_abort,
  input  logic [N_CH-1:0]      ch_ready,
  input  logic [N_CH-1:0]      ch_wr,
  input  logic [32*N_CH-1:0]   ch_rd,
  output logic [N_CH-1:0]      err_flags,
  input  logic [N_CH-1:0]      err_clear
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t          state, state_nx;
  logic [15:0]     cnt, cnt_nx;
  logic [CH_W-1:0] ch_sel, dec_ch;
  logic            claim, load;
  logic [N_CH-1:0] dec_onehot, sel_onehot;
  logic            sel_ready, sel_wr, timeout_hit;
  logic [31:0]     sel_rd;

  logic            wr_nx, wait_nx, ready_nx;
  logic [31:0]     rd_nx;
  logic [N_CH-1:0] valid_nx, abort_nx, err_set;

  pcpi_match #(
    .N_CH   (N_CH),
    .OPCODE (OPCODE),
    .CH_W   (CH_W)
  ) u_match (
    .opcode (pcpi_insn[OPCODE_MSB:OPCODE_LSB]),
    .funct7 (pcpi_insn[FUNCT7_MSB:FUNCT7_LSB]),
    .claim  (claim),
    .ch     (dec_ch)
  );

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      dec_onehot[i] = (dec_ch == CH_W'(i));
      sel_onehot[i] = (ch_sel == CH_W'(i));
    end
  end

  assign sel_ready   = |(ch_ready & sel_onehot);
  assign sel_wr      = |(ch_wr & sel_onehot);
  assign sel_rd      = ch_rd[{ch_sel, 5'd0} +: 32];
  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

  // Outputs are computed for the state being entered so that every output
  // comes straight from a flop; a dropped valid takes priority over a result.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    wr_nx    = 1'b0;
    rd_nx    = '0;
    wait_nx  = 1'b0;
    ready_nx = 1'b0;
    valid_nx = '0;
    abort_nx = '0;
    err_set  = '0;
    case (state)
      ST_IDLE: begin
        if (pcpi_valid && claim) begin
          state_nx = ST_BUSY;
          cnt_nx   = '0;
          load     = 1'b1;
          wait_nx  = 1'b1;
          valid_nx = dec_onehot;
        end
      end
      ST_BUSY: begin
        if (!pcpi_valid) begin
          state_nx = ST_IDLE;
          abort_nx = sel_onehot;
        end else if (sel_ready) begin
          state_nx = ST_RESP;
          wait_nx  = 1'b1;
          ready_nx = 1'b1;
          wr_nx    = sel_wr;
          rd_nx    = sel_rd;
        end else if (timeout_hit) begin
          state_nx = ST_RESP;
          wait_nx  = 1'b1;
          ready_nx = 1'b1;
          wr_nx    = 1'b1;
          rd_nx    = ERR_VALUE;
          abort_nx = sel_onehot;
          err_set  = sel_onehot;
        end else begin
          cnt_nx   = cnt + 16'd1;
          wait_nx  = 1'b1;
          valid_nx = sel_onehot;
        end
      end
      ST_RESP:  state_nx = ST_DRAIN;
      ST_DRAIN: if (!pcpi_valid) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ch_sel     <= '0;
      ch_insn    <= '0;
      ch_rs1     <= '0;
      ch_rs2     <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      ch_valid   <= '0;
      ch_abort   <= '0;
      err_flags  <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pcpi_wr    <= wr_nx;
      pcpi_rd    <= rd_nx;
      pcpi_wait  <= wait_nx;
      pcpi_ready <= ready_nx;
      ch_valid   <= valid_nx;
      ch_abort   <= abort_nx;
      err_flags  <= (err_flags & ~err_clear) | err_set;
      if (load) begin
        ch_sel  <= dec_ch;
        ch_insn <= pcpi_insn;
        ch_rs1  <= pcpi_rs1;
        ch_rs2  <= pcpi_rs2;
      end
    end
  end

endmodule
